// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA Montgomery-constant scheduler: widths, op codes, FSM states.
package rsa_pkg;

  localparam int W_RSA = 4096;

  localparam logic OP_R  = 1'b0;
  localparam logic OP_R2 = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_GUARD,
    S_WAIT,
    S_RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         win_oh,
  output logic [$clog2(NREQ)-1:0] win_idx,
  output logic                    found
);

  localparam int IW = $clog2(NREQ);

  always_comb begin : pick
    int idx;
    idx     = 0;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_idx     = IW'(idx);
        win_oh[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rsa_const_sched.sv
// Round-robin scheduler sharing one R / R^2 mod n engine between NREQ requesters.
// Define RSA_CONST_CACHE_EN to add a last-result cache that bypasses the engine on a repeat request.
module rsa_const_sched
  import rsa_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_RSA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     req_mode,
  input  logic [NREQ*W-1:0]   req_n,
  output logic [NREQ-1:0]     grant,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [W-1:0]        rsp_r,
  output logic                busy,
  output logic                eng_go,
  output logic                eng_mode,
  output logic [W-1:0]        eng_n,
  input  logic [W-1:0]        eng_r,
  input  logic                eng_done
);

  localparam int IW = $clog2(NREQ);

  sched_state_t    state, state_nxt;
  logic [IW-1:0]   rr_ptr, win_idx, arb_idx;
  logic [NREQ-1:0] win_oh, arb_oh;
  logic            arb_found;
  logic [W-1:0]    sel_n;
  logic            sel_mode;
  logic            cache_hit;
  logic [W-1:0]    cached_r;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win_oh  (arb_oh),
    .win_idx (arb_idx),
    .found   (arb_found)
  );

  assign sel_n    = req_n[arb_idx*W +: W];
  assign sel_mode = req_mode[arb_idx];

`ifdef RSA_CONST_CACHE_EN
  logic         cache_valid;
  logic         cache_mode;
  logic [W-1:0] cache_n;
  logic [W-1:0] cache_r;

  // Only validity needs reset; contents are meaningless until the first completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
    end else if (state == S_WAIT && eng_done) begin
      cache_valid <= 1'b1;
      cache_mode  <= eng_mode;
      cache_n     <= eng_n;
      cache_r     <= eng_r;
    end
  end

  assign cache_hit = cache_valid && (cache_n == sel_n) && (cache_mode == sel_mode);
  assign cached_r  = cache_r;
`else
  assign cache_hit = 1'b0;
  assign cached_r  = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // GUARD exists so a done left high by the previous op is never taken as completion.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (arb_found) state_nxt = cache_hit ? S_RESP : S_LAUNCH;
      S_LAUNCH: state_nxt = S_GUARD;
      S_GUARD:  state_nxt = S_WAIT;
      S_WAIT:   if (eng_done) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    rsp_valid = '0;
    eng_go    = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_LAUNCH: begin
        eng_go = 1'b1;
        grant  = win_oh;
      end
      S_GUARD, S_WAIT: grant = win_oh;
      S_RESP: begin
        grant     = win_oh;
        rsp_valid = win_oh;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      win_idx  <= '0;
      win_oh   <= '0;
      eng_mode <= OP_R;
      eng_n    <= '0;
      rsp_r    <= '0;
    end else begin
      if (state == S_IDLE && arb_found) begin
        win_idx  <= arb_idx;
        win_oh   <= arb_oh;
        eng_mode <= sel_mode;
        eng_n    <= sel_n;
        if (cache_hit) rsp_r <= cached_r;
      end
      if (state == S_WAIT && eng_done) rsp_r <= eng_r;
      if (state == S_RESP) rr_ptr <= (win_idx == IW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule
